qspi_arbiter: RTL and testbench

QSPI_ARBITER -- requirements
Module: qspi_arbiter

---
 rtl/qspi_arbiter_if.sv | 47 ++++
 rtl/qspi_arbiter.sv | 123 ++++++++++++
 tb/tb_qspi_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_arbiter_if.sv
// Bus bundle between the two flash requesters, the arbiter and the QSPI engine.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface qspi_arbiter_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              r0_valid;
    logic [ADDR_W-1:0] r0_addr;
    logic [1:0]        r0_cs;
    logic              r0_ready;
    logic [31:0]       r0_rdata;

    logic              r1_valid;
    logic [ADDR_W-1:0] r1_addr;
    logic [1:0]        r1_cs;
    logic              r1_lock;
    logic              r1_ready;
    logic [31:0]       r1_rdata;

    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_cs;
    logic              m_ready;
    logic [31:0]       m_rdata;

    logic [1:0]        grant;
    logic              busy;

    modport master (
        input  r0_valid, r0_addr, r0_cs,
        output r0_ready, r0_rdata,
        input  r1_valid, r1_addr, r1_cs, r1_lock,
        output r1_ready, r1_rdata,
        output m_valid, m_addr, m_cs,
        input  m_ready, m_rdata,
        output grant, busy
    );

    modport slave (
        output r0_valid, r0_addr, r0_cs,
        input  r0_ready, r0_rdata,
        output r1_valid, r1_addr, r1_cs, r1_lock,
        input  r1_ready, r1_rdata,
        input  m_valid, m_addr, m_cs,
        output m_ready, m_rdata,
        input  grant, busy
    );
endinterface

// File: rtl/qspi_arbiter.sv
// Two-requester round-robin arbiter in front of a single QSPI read engine,
// with a loader bus lock and a forced chip-select deselect gap between transactions.
module qspi_arbiter #(
    parameter int unsigned CS_GAP = 2,
    parameter int unsigned ADDR_W = 24
) (
    input  logic          clk,
    input  logic          reset,
    qspi_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_e;

    localparam logic [3:0] GAP_LAST = (CS_GAP == 0) ? 4'd0 : 4'(CS_GAP - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [1:0]        m_cs_q, m_cs_d;
    logic [31:0]       r0_rdata_q, r0_rdata_d;
    logic [31:0]       r1_rdata_q, r1_rdata_d;
    logic              r0_ready_q, r0_ready_d;
    logic              r1_ready_q, r1_ready_d;

    logic              lock_active;
    logic              r0_elig;
    logic              pick_r1;
    logic              in_txn;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        gap_cnt_d  = gap_cnt_q;
        m_addr_d   = m_addr_q;
        m_cs_d     = m_cs_q;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
        r0_ready_d = 1'b0;
        r1_ready_d = 1'b0;

        // A locking loader that completed last keeps the bus; r0 is then ineligible.
        lock_active = last_q && bus.r1_lock;
        r0_elig     = bus.r0_valid && !lock_active;
        pick_r1     = bus.r1_valid && (!r0_elig || !last_q);

        case (state_q)
            IDLE: begin
                if (r0_elig || bus.r1_valid) begin
                    owner_d  = pick_r1;
                    m_addr_d = pick_r1 ? bus.r1_addr : bus.r0_addr;
                    m_cs_d   = pick_r1 ? bus.r1_cs : bus.r0_cs;
                    state_d  = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (bus.m_ready) begin
                    if (owner_q) begin
                        r1_rdata_d = bus.m_rdata;
                        r1_ready_d = 1'b1;
                    end else begin
                        r0_rdata_d = bus.m_rdata;
                        r0_ready_d = 1'b1;
                    end
                    last_d    = owner_q;
                    gap_cnt_d = 4'd0;
                    state_d   = (CS_GAP == 0) ? IDLE : GAP;
                end else begin
                    state_d = WAIT;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            gap_cnt_q  <= 4'd0;
            m_addr_q   <= '0;
            m_cs_q     <= 2'd0;
            r0_rdata_q <= 32'd0;
            r1_rdata_q <= 32'd0;
            r0_ready_q <= 1'b0;
            r1_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            m_addr_q   <= m_addr_d;
            m_cs_q     <= m_cs_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
            r0_ready_q <= r0_ready_d;
            r1_ready_q <= r1_ready_d;
        end
    end

    assign in_txn       = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.m_valid  = in_txn;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_cs     = m_cs_q;
    assign bus.grant    = in_txn ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.busy     = (state_q != IDLE);
    assign bus.r0_ready = r0_ready_q;
    assign bus.r0_rdata = r0_rdata_q;
    assign bus.r1_ready = r1_ready_q;
    assign bus.r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Bench for qspi_arbiter: table of arbitration vectors driven through an engine model,
// completions matched against a scoreboard, plus reset, lock and CS_GAP=0 sequences.
module tb_qspi_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_ready_cyc = -1;
    bit   mon_en = 1'b0;
    bit   ok;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qspi_arbiter_if #(.ADDR_W(24)) ifa ();
    qspi_arbiter_if #(.ADDR_W(24)) if0 ();

    qspi_arbiter #(.CS_GAP(2), .ADDR_W(24)) dut  (.clk(clk), .reset(reset), .bus(ifa));
    qspi_arbiter #(.CS_GAP(0), .ADDR_W(24)) dut0 (.clk(clk), .reset(reset), .bus(if0));

    typedef struct {
        logic        own;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];
    sb_t mon_e;
    logic [31:0] exp_rd0 = 32'd0;
    logic [31:0] exp_rd1 = 32'd0;

    typedef struct {
        logic        r0v;
        logic [23:0] a0;
        logic [1:0]  c0;
        logic        r1v;
        logic [23:0] a1;
        logic [1:0]  c1;
        logic        lk;
        logic [31:0] data;
        int          dly;
        logic        own;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mvalid(output bit got);
        int t = 0;
        while (!ifa.m_valid && t < 40) begin
            step();
            t++;
        end
        got = ifa.m_valid;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL m_valid_timeout: actual 0 required 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (ifa.busy && t < 40) begin
            step();
            t++;
        end
        chk("idle_timeout", ifa.busy, 1'b0);
    endtask

    // Engine model: accept the granted request, answer after dly cycles, expect its completion.
    task automatic engine_txn(input logic own, input logic [23:0] addr, input logic [1:0] cs,
                              input logic [31:0] data, input int dly);
        bit got;
        wait_mvalid(got);
        if (!got) return;
        if (last_ready_cyc >= 0) chk("gap_len", 64'(cyc - last_ready_cyc), 64'd4);
        chk("m_addr", ifa.m_addr, addr);
        chk("m_cs", ifa.m_cs, cs);
        chk("grant", ifa.grant, own ? 2'b10 : 2'b01);
        chk("busy_txn", ifa.busy, 1'b1);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("hold_valid", ifa.m_valid, 1'b1);
            chk("hold_addr", ifa.m_addr, addr);
            chk("hold_grant", ifa.grant, own ? 2'b10 : 2'b01);
        end
        ifa.m_ready = 1'b1;
        ifa.m_rdata = data;
        sb.push_back('{own, data});
        last_ready_cyc = cyc;
        step();
        ifa.m_ready = 1'b0;
        ifa.m_rdata = $urandom;
        chk("mvalid_drop", ifa.m_valid, 1'b0);
        chk("grant_gap", ifa.grant, 2'b00);
    endtask

    // Completion monitor for the CS_GAP=2 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ifa.r0_ready || ifa.r1_ready) begin
                chk("ready_onehot", ifa.r0_ready & ifa.r1_ready, 1'b0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: actual r0=%0b r1=%0b required none (cycle %0d)",
                             ifa.r0_ready, ifa.r1_ready, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ready_owner", ifa.r1_ready, mon_e.own);
                    if (mon_e.own) exp_rd1 = mon_e.data;
                    else           exp_rd0 = mon_e.data;
                end
            end
            chk("r0_rdata", ifa.r0_rdata, exp_rd0);
            chk("r1_rdata", ifa.r1_rdata, exp_rd1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 24'h000100, 2'd0, 1'b0, 24'h000000, 2'd0, 1'b0, 32'hDEADBEEF, 3, 1'b0};
        tbl[1]  = '{1'b0, 24'h000000, 2'd0, 1'b1, 24'h123456, 2'd2, 1'b0, 32'h11111111, 0, 1'b1};
        tbl[2]  = '{1'b1, 24'h000200, 2'd1, 1'b1, 24'h000300, 2'd3, 1'b0, 32'h22222222, 2, 1'b0};
        tbl[3]  = '{1'b1, 24'h000200, 2'd1, 1'b1, 24'h000300, 2'd3, 1'b0, 32'h33333333, 1, 1'b1};
        tbl[4]  = '{1'b1, 24'h000200, 2'd1, 1'b1, 24'h000300, 2'd3, 1'b0, 32'h44444444, 0, 1'b0};
        tbl[5]  = '{1'b1, 24'h000200, 2'd1, 1'b1, 24'h000300, 2'd3, 1'b0, 32'h55555555, 4, 1'b1};
        tbl[6]  = '{1'b1, 24'h000204, 2'd1, 1'b1, 24'h000304, 2'd2, 1'b1, 32'h66666666, 1, 1'b1};
        tbl[7]  = '{1'b1, 24'h000204, 2'd1, 1'b1, 24'h000308, 2'd2, 1'b1, 32'h77777777, 2, 1'b1};
        tbl[8]  = '{1'b1, 24'h000204, 2'd1, 1'b1, 24'h00030C, 2'd2, 1'b1, 32'h88888888, 1, 1'b1};
        tbl[9]  = '{1'b1, 24'h000204, 2'd1, 1'b1, 24'h000310, 2'd2, 1'b1, 32'h99999999, 0, 1'b1};
        tbl[10] = '{1'b1, 24'h000204, 2'd1, 1'b1, 24'h000314, 2'd2, 1'b0, 32'hAAAAAAAA, 1, 1'b0};
        tbl[11] = '{1'b1, 24'h000208, 2'd0, 1'b1, 24'h000318, 2'd1, 1'b1, 32'hBBBBBBBB, 1, 1'b1};

        reset = 1'b1;
        ifa.r0_valid = 0; ifa.r0_addr = '0; ifa.r0_cs = 0;
        ifa.r1_valid = 0; ifa.r1_addr = '0; ifa.r1_cs = 0; ifa.r1_lock = 0;
        ifa.m_ready = 0;  ifa.m_rdata = 0;
        if0.r0_valid = 0; if0.r0_addr = '0; if0.r0_cs = 0;
        if0.r1_valid = 0; if0.r1_addr = '0; if0.r1_cs = 0; if0.r1_lock = 0;
        if0.m_ready = 0;  if0.m_rdata = 0;
        repeat (3) step();
        chk("rst_m_valid", ifa.m_valid, 1'b0);
        chk("rst_m_addr", ifa.m_addr, 24'h0);
        chk("rst_grant", ifa.grant, 2'b00);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_ready", {ifa.r0_ready, ifa.r1_ready}, 2'b00);
        chk("rst_rdata", {ifa.r0_rdata, ifa.r1_rdata}, 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            ifa.r0_valid = tbl[i].r0v; ifa.r0_addr = tbl[i].a0; ifa.r0_cs = tbl[i].c0;
            ifa.r1_valid = tbl[i].r1v; ifa.r1_addr = tbl[i].a1; ifa.r1_cs = tbl[i].c1;
            ifa.r1_lock  = tbl[i].lk;
            engine_txn(tbl[i].own, tbl[i].own ? tbl[i].a1 : tbl[i].a0,
                       tbl[i].own ? tbl[i].c1 : tbl[i].c0, tbl[i].data, tbl[i].dly);
        end

        // Locked loader completed last: a lone r0 request must wait until the lock drops.
        ifa.r0_valid = 1; ifa.r0_addr = 24'h000500; ifa.r0_cs = 2'd1;
        ifa.r1_valid = 0; ifa.r1_lock = 1;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_busy", ifa.busy, 1'b0);
            chk("lock_grant", ifa.grant, 2'b00);
        end
        ifa.r1_lock = 0;
        last_ready_cyc = -1;
        engine_txn(1'b0, 24'h000500, 2'd1, 32'hCAFE0001, 1);

        // Requester drops valid and changes address after grant; latched request completes.
        ifa.r0_addr = 24'h0ABCDE; ifa.r0_cs = 2'd2;
        wait_mvalid(ok);
        ifa.r0_valid = 0; ifa.r0_addr = 24'hFFFFFF; ifa.r0_cs = 2'd0;
        last_ready_cyc = -1;
        engine_txn(1'b0, 24'h0ABCDE, 2'd2, 32'h12345678, 2);

        // Stray engine completion while idle.
        wait_idle();
        ifa.m_ready = 1; ifa.m_rdata = 32'hBAD0BAD0;
        step();
        ifa.m_ready = 0;
        chk("stray_busy", ifa.busy, 1'b0);
        chk("stray_m_valid", ifa.m_valid, 1'b0);
        step();
        chk("stray_ready", {ifa.r0_ready, ifa.r1_ready}, 2'b00);

        // Reset in WAIT with the engine answering during and after reset.
        ifa.r1_valid = 1; ifa.r1_addr = 24'h000777; ifa.r1_cs = 2'd3;
        wait_mvalid(ok);
        chk("pre_rst_grant", ifa.grant, 2'b10);
        step();
        chk("wait_busy", ifa.busy, 1'b1);
        chk("wait_m_valid", ifa.m_valid, 1'b1);
        mon_en = 1'b0;
        reset = 1'b1; ifa.r1_valid = 0;
        ifa.m_ready = 1; ifa.m_rdata = 32'h77777777;
        step();
        chk("mrst_m_valid", ifa.m_valid, 1'b0);
        chk("mrst_m_addr", ifa.m_addr, 24'h0);
        chk("mrst_m_cs", ifa.m_cs, 2'd0);
        chk("mrst_grant", ifa.grant, 2'b00);
        chk("mrst_busy", ifa.busy, 1'b0);
        chk("mrst_ready", {ifa.r0_ready, ifa.r1_ready}, 2'b00);
        chk("mrst_rdata", {ifa.r0_rdata, ifa.r1_rdata}, 64'd0);
        exp_rd0 = 32'd0; exp_rd1 = 32'd0;
        sb.delete();
        reset = 1'b0;
        step();
        ifa.m_ready = 0;
        chk("post_rst_ready", {ifa.r0_ready, ifa.r1_ready}, 2'b00);
        chk("post_rst_busy", ifa.busy, 1'b0);
        mon_en = 1'b1;
        step();
        chk("post_rst_ready2", {ifa.r0_ready, ifa.r1_ready}, 2'b00);
        ifa.r0_valid = 1; ifa.r0_addr = 24'h000010; ifa.r0_cs = 2'd0;
        ifa.r1_valid = 1; ifa.r1_addr = 24'h000020; ifa.r1_cs = 2'd1; ifa.r1_lock = 0;
        last_ready_cyc = -1;
        engine_txn(1'b0, 24'h000010, 2'd0, 32'h0F0F0F0F, 1);
        ifa.r0_valid = 0; ifa.r1_valid = 0;
        wait_idle();
        step();

        // CS_GAP=0 instance: back-to-back r0, then r1 on chip select 3.
        if0.r0_valid = 1; if0.r0_addr = 24'h000040; if0.r0_cs = 2'd1;
        begin
            int t = 0;
            while (!if0.m_valid && t < 20) begin
                step();
                t++;
            end
        end
        chk("g0_m_valid", if0.m_valid, 1'b1);
        chk("g0_m_addr", if0.m_addr, 24'h000040);
        chk("g0_grant", if0.grant, 2'b01);
        step();
        if0.m_ready = 1; if0.m_rdata = 32'hA5A50001;
        step();
        if0.m_ready = 0;
        if0.r0_addr = 24'h000044;
        chk("g0_r0_ready", if0.r0_ready, 1'b1);
        chk("g0_r0_rdata", if0.r0_rdata, 32'hA5A50001);
        chk("g0_gap_valid", if0.m_valid, 1'b0);
        chk("g0_gap_busy", if0.busy, 1'b0);
        step();
        chk("g0_b2b_valid", if0.m_valid, 1'b1);
        chk("g0_b2b_addr", if0.m_addr, 24'h000044);
        chk("g0_r0_ready_low", if0.r0_ready, 1'b0);
        if0.r0_valid = 0;
        if0.r1_valid = 1; if0.r1_addr = 24'h000080; if0.r1_cs = 2'd3;
        if0.m_ready = 1; if0.m_rdata = 32'hA5A50002;
        step();
        if0.m_ready = 0;
        chk("g0_r0_ready2", if0.r0_ready, 1'b1);
        chk("g0_r0_rdata2", if0.r0_rdata, 32'hA5A50002);
        chk("g0_r1_rdata_hold", if0.r1_rdata, 32'd0);
        step();
        chk("g0_r1_valid", if0.m_valid, 1'b1);
        chk("g0_r1_cs", if0.m_cs, 2'd3);
        chk("g0_r1_addr", if0.m_addr, 24'h000080);
        chk("g0_r1_grant", if0.grant, 2'b10);
        if0.m_ready = 1; if0.m_rdata = 32'hA5A50003;
        step();
        if0.m_ready = 0;
        if0.r1_valid = 0;
        chk("g0_r1_ready", {if0.r1_ready, if0.r0_ready}, 2'b10);
        chk("g0_r1_rdata", if0.r1_rdata, 32'hA5A50003);
        chk("g0_r0_rdata_hold", if0.r0_rdata, 32'hA5A50002);
        step();
        chk("g0_r1_ready_low", if0.r1_ready, 1'b0);
        chk("g0_end_busy", if0.busy, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
